// File: rtl/hex_entry_reg_pkg.sv
// Shared display-path definitions for the hex-digit entry register.
// Holds the state encoding and the word geometry.
package hex_entry_reg_pkg;

    localparam int DIGITS = 8;
    localparam int NW     = 4;
    localparam int DW     = DIGITS * NW;
    localparam int CW     = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ENTRY = 2'b01,
        FULL  = 2'b10
    } state_e;

endpackage

// File: rtl/hex_entry_reg_rise_edge.sv
// Rising-edge detector for one debounced level input.
// The history flop resets to RST_VAL, so a level already high at reset release is not an edge.
module rise_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic edge_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= in_i;
        end
    end

    assign edge_o = in_i & ~prev_q;

endmodule

// File: rtl/hex_entry_reg.sv
// Calculator-style hex-digit entry: new digits enter at D[3:0] and older digits shift left.
// Acts on rising edges of enter/bksp/clr, with clr > bksp > enter when edges coincide.
module hex_entry_reg
    import hex_entry_reg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NW-1:0]     nib_in,
    input  logic              enter,
    input  logic              bksp,
    input  logic              clr,
    output logic [DW-1:0]     D,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              done,
    output state_e            dbg_state
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    logic enter_edge;
    logic bksp_edge;
    logic clr_edge;

    state_e          state_q, state_d;
    logic [DW-1:0]   d_q, d_d;
    logic [CW-1:0]   count_q, count_d;
    logic            done_q, done_d;

    rise_edge #(.RST_VAL(1'b1)) u_enter_edge (
        .clk_i  (clk),
        .rst_i  (reset),
        .in_i   (enter),
        .edge_o (enter_edge)
    );

    rise_edge #(.RST_VAL(1'b1)) u_bksp_edge (
        .clk_i  (clk),
        .rst_i  (reset),
        .in_i   (bksp),
        .edge_o (bksp_edge)
    );

    rise_edge #(.RST_VAL(1'b1)) u_clr_edge (
        .clk_i  (clk),
        .rst_i  (reset),
        .in_i   (clr),
        .edge_o (clr_edge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            d_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Lower-priority edges in the same cycle are dropped, never queued.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        count_d = count_q;
        done_d  = 1'b0;

        if (clr_edge) begin
            state_d = EMPTY;
            d_d     = '0;
            count_d = '0;
        end else if (bksp_edge) begin
            if (state_q != EMPTY) begin
                d_d     = {{NW{1'b0}}, d_q[DW-1:NW]};
                count_d = count_q - CNT_ONE;
                state_d = (count_q == CNT_ONE) ? EMPTY : ENTRY;
            end
        end else if (enter_edge) begin
            if (state_q != FULL) begin
                d_d     = {d_q[DW-NW-1:0], nib_in};
                count_d = count_q + CNT_ONE;
                if (count_q == CNT_LAST) begin
                    state_d = FULL;
                    done_d  = 1'b1;
                end else begin
                    state_d = ENTRY;
                end
            end
        end
    end

    assign D         = d_q;
    assign count     = count_q;
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: doc/hex_entry_reg.md
# hex_entry_reg

Hex-digit entry register for the display path: builds the 32-bit, 8-nibble word that the seven-segment display mux scans out, one nibble at a time. Digit entry is calculator style: each new hex digit enters at the least-significant nibble and earlier digits shift left. The block takes debounced level inputs from switches and buttons, acts only on their rising edges, and supports backspace and clear. Its output word drives the display mux data input directly.

## Interface
- DIGITS, 8: number of nibble positions (fixed at 8 for the display path)
- NW, 4: nibble width
- clk  in  1: system clock
- reset  in  1: asynchronous, active-high reset
- nib_in  in  4: hex digit from the switches; sampled on the enter edge
- enter  in  1: debounced level; its rising edge appends nib_in
- bksp  in  1: debounced level; its rising edge deletes the last digit
- clr  in  1: debounced level; its rising edge clears the word
- D  out  32: assembled word; D[3:0] is the most recent digit
- count  out  4: digits entered, 0..8
- full  out  1: count == 8
- empty  out  1: count == 0
- done  out  1: one-cycle pulse when the 8th digit is accepted

## Operation
- Edge detection:
  - One history flop per command input (enter, bksp, clr).
  - A command's edge is `in & ~prev`.
  - prev flops reset to 1. An input held high across reset release produces no action until it goes low and then high again.
- Priority among edges detected in the same cycle: clr > bksp > enter. Lower-priority edges in that cycle are discarded, not deferred.
- States: EMPTY (count 0), ENTRY (count 1..7), FULL (count 8).
- clr edge, any state: D=0, count=0, go to EMPTY.
- enter edge:
  - EMPTY or ENTRY: D = {D[27:0], nib_in}, count+1. Go to FULL if count was 7, otherwise ENTRY.
  - FULL: ignored; D and count unchanged.
- bksp edge:
  - ENTRY or FULL: D = {4'h0, D[31:4]}, count−1. Go to EMPTY if count was 1, otherwise ENTRY.
  - EMPTY: ignored.
- done asserts only on the ENTRY→FULL transition. It never asserts on a FULL→FULL ignore or after a bksp/enter re-fill that does not pass through count 7→8.
- count never wraps. No increment past 8, no decrement below 0.
- full and empty decode combinationally from count.
- Leading-zero digits are valid. Entering 0 still increments count.

## Timing
- Reset values: D=0, count=0, full=0, empty=1, done=0, all prev flops=1, state EMPTY.
- Latency: an input first sampled high at clock edge k (low at edge k−1):
  - D and count update at edge k.
  - done is high from edge k to edge k+1.
- nib_in is sampled only at edge k. It may change at any other time.
- Minimum spacing between actions is one cycle low plus one cycle high per input. Back-to-back pulses on different inputs in consecutive cycles each act.
- Reset mid-operation: asynchronous, immediate return to reset values. done drops within the same cycle.

## Structure
- The shared display package holds:
  - state encoding: EMPTY=2'b00, ENTRY=2'b01, FULL=2'b10
  - constants DIGITS and NW
- One natural sub-module: rise_edge, a single flop with parameterised reset value plus the `in & ~prev` output. It is instantiated three times. All other logic lives in this block.

## Test plan
- Reset, then enter digits 1,2,3,4,5,6,7,8 with nib_in matching each digit:
  - D=32'h12345678, count=8, full=1.
  - done high exactly one cycle, on the 8th edge.
- From FULL, enter nib_in=4'hF: D stays 32'h12345678, count stays 8, done stays 0.
- From D=32'h00000ABC (count 3):
  - bksp gives 32'h000000AB, count=2.
  - Two more bksp give D=0, empty=1.
  - A fourth bksp leaves count=0.
- clr, bksp and enter rising in the same cycle, from count 5: D=0, count=0, no done.
- enter held high through reset release: no digit accepted. After low-then-high with nib_in=4'h9: D=32'h00000009.
- Assert reset while count=6: D=0 and count=0 before the next clock edge. A subsequent enter is accepted normally.
